// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: scans the key bitmap once per tick, releases voices of lifted keys,
// then assigns new presses to free voices, stealing the oldest voice when the pool is full.
module voice_allocator #(
  parameter int  NUM_KEYS   = 32,
  parameter int  NUM_VOICES = 4,
  parameter int  AGE_W      = 4,
  localparam int KEY_W      = $clog2(NUM_KEYS)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NUM_KEYS-1:0]         i_keys,
  input  logic                        i_tick,
  output logic [NUM_VOICES-1:0]       o_voice_active,
  output logic [NUM_VOICES*KEY_W-1:0] o_voice_key,
  output logic [NUM_VOICES-1:0]       o_voice_trig,
  output logic                        o_steal,
  output logic                        o_busy,
  output logic                        o_overrun
);

  localparam int               VIDX_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [KEY_W-1:0] LAST_KEY = KEY_W'(NUM_KEYS - 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_REL, S_PRS} state_t;
  state_t state, state_nxt;

  logic [NUM_KEYS-1:0]   prev, snap;
  logic [KEY_W-1:0]      idx;
  logic [NUM_VOICES-1:0] active;
  logic [KEY_W-1:0]      key [NUM_VOICES];
  logic [AGE_W-1:0]      age [NUM_VOICES];

  logic              last_key, rel_hit, prs_hit, free_found;
  logic [VIDX_W-1:0] free_sel, old_sel, sel;
  logic [AGE_W-1:0]  old_age;

  function automatic logic [AGE_W-1:0] age_inc_sat(input logic [AGE_W-1:0] a);
    return (a == AGE_MAX) ? a : a + AGE_W'(1);
  endfunction

  always_comb begin
    last_key = (idx == LAST_KEY);
    rel_hit  = (state == S_REL) && prev[idx] && !snap[idx];
    prs_hit  = (state == S_PRS) && !prev[idx] && snap[idx];

    free_found = 1'b0;
    free_sel   = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!active[v]) begin
        free_found = 1'b1;
        free_sel   = VIDX_W'(v);
      end
    end

    // Strict compare keeps the lowest index on equal ages
    old_sel = '0;
    old_age = age[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age[v] > old_age) begin
        old_sel = VIDX_W'(v);
        old_age = age[v];
      end
    end

    sel = free_found ? free_sel : old_sel;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_tick) state_nxt = S_REL;
      S_REL:   if (last_key) state_nxt = S_PRS;
      S_PRS:   if (last_key) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      prev      <= '0;
      snap      <= '0;
      o_overrun <= 1'b0;
    end else begin
      state     <= state_nxt;
      o_overrun <= i_tick && (state != S_IDLE);
      if (state == S_IDLE) begin
        if (i_tick) begin
          snap <= i_keys;
          prev <= snap;
          idx  <= '0;
        end
      end else begin
        idx <= last_key ? '0 : idx + KEY_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      active       <= '0;
      o_voice_trig <= '0;
      o_steal      <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        key[v] <= '0;
        age[v] <= '0;
      end
    end else begin
      o_voice_trig <= '0;
      o_steal      <= 1'b0;
      if (rel_hit) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (active[v] && (key[v] == idx)) active[v] <= 1'b0;
        end
      end
      if (prs_hit) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (VIDX_W'(v) == sel) begin
            active[v]       <= 1'b1;
            key[v]          <= idx;
            age[v]          <= '0;
            o_voice_trig[v] <= 1'b1;
          end else if (active[v]) begin
            age[v] <= age_inc_sat(age[v]);
          end
        end
        o_steal <= !free_found;
      end
    end
  end

  always_comb begin
    o_voice_key = '0;
    for (int v = 0; v < NUM_VOICES; v++) o_voice_key[KEY_W*v +: KEY_W] = key[v];
  end

  assign o_voice_active = active;
  assign o_busy         = (state != S_IDLE);

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios plus random bitmaps against a scan-level reference.
module tb_voice_allocator;

  localparam int NK = 32;
  localparam int NV = 4;
  localparam int KW = 5;
  localparam int AW = 4;
  localparam int AGE_MAX = (1 << AW) - 1;

  logic           i_clk = 1'b0;
  logic           i_rst_n = 1'b0;
  logic [NK-1:0]  i_keys = '0;
  logic           i_tick = 1'b0;
  logic [NV-1:0]  o_voice_active;
  logic [NV*KW-1:0] o_voice_key;
  logic [NV-1:0]  o_voice_trig;
  logic           o_steal, o_busy, o_overrun;

  voice_allocator #(.NUM_KEYS(NK), .NUM_VOICES(NV), .AGE_W(AW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_keys(i_keys), .i_tick(i_tick),
    .o_voice_active(o_voice_active), .o_voice_key(o_voice_key),
    .o_voice_trig(o_voice_trig), .o_steal(o_steal), .o_busy(o_busy),
    .o_overrun(o_overrun)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference state: whole-scan view of the voice pool
  logic [NK-1:0] m_prev, m_snap;
  logic [NV-1:0] m_act;
  logic [KW-1:0] m_key [NV];
  int            m_age [NV];
  int            e_trig, e_steal;

  task automatic model_reset();
    m_prev = '0; m_snap = '0; m_act = '0;
    for (int v = 0; v < NV; v++) begin m_key[v] = '0; m_age[v] = 0; end
  endtask

  task automatic model_scan(input logic [NK-1:0] keys);
    int s;
    m_prev = m_snap; m_snap = keys; e_trig = 0; e_steal = 0;
    for (int k = 0; k < NK; k++)
      if (m_prev[k] && !m_snap[k])
        for (int v = 0; v < NV; v++)
          if (m_act[v] && m_key[v] == KW'(k)) m_act[v] = 1'b0;
    for (int k = 0; k < NK; k++) begin
      if (!m_prev[k] && m_snap[k]) begin
        s = -1;
        for (int v = 0; v < NV; v++) if (!m_act[v] && s < 0) s = v;
        if (s < 0) begin
          s = 0;
          for (int v = 1; v < NV; v++) if (m_age[v] > m_age[s]) s = v;
          e_steal++;
        end
        for (int v = 0; v < NV; v++)
          if (v != s && m_act[v]) m_age[v] = (m_age[v] < AGE_MAX) ? m_age[v] + 1 : AGE_MAX;
        m_act[s] = 1'b1; m_key[s] = KW'(k); m_age[s] = 0; e_trig++;
      end
    end
  endtask

  function automatic logic [NV*KW-1:0] model_keys();
    logic [NV*KW-1:0] r;
    for (int v = 0; v < NV; v++) r[v*KW +: KW] = m_key[v];
    return r;
  endfunction

  task automatic do_reset();
    i_rst_n = 1'b0; i_keys = '1;
    for (int c = 0; c < 4; c++) begin
      i_tick = c[0];
      @(negedge i_clk);
      chk("rst_outs", {o_voice_active, o_voice_key, o_voice_trig, o_steal, o_busy, o_overrun}, '0);
    end
    i_tick = 1'b0; i_rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      chk("post_rst_outs", {o_voice_active, o_voice_key, o_voice_trig, o_steal, o_busy, o_overrun}, '0);
    end
    model_reset();
  endtask

  // Called on a negedge with o_busy low; returns on the first idle negedge after the scan
  task automatic do_scan(input logic [NK-1:0] keys, input int ovr_at, input logic [NK-1:0] ovr_keys);
    int busy_n = 0, trig_n = 0, steal_n = 0, multi = 0, ovr_n = 0;
    logic last_busy = 1'b0;
    i_keys = keys; i_tick = 1'b1;
    model_scan(keys);
    @(negedge i_clk);
    i_tick = 1'b0;
    for (int c = 0; c <= 2*NK; c++) begin
      busy_n  += int'(o_busy);
      last_busy = o_busy;
      trig_n  += $countones(o_voice_trig);
      if ($countones(o_voice_trig) > 1) multi++;
      steal_n += int'(o_steal);
      ovr_n   += int'(o_overrun);
      if (c == ovr_at) begin i_keys = ovr_keys; i_tick = 1'b1; end
      if (c == ovr_at + 1) i_tick = 1'b0;
      if (c < 2*NK) @(negedge i_clk);
    end
    chk("busy_cycles", busy_n, 2*NK);
    chk("busy_end", last_busy, 1'b0);
    chk("trig_count", trig_n, e_trig);
    chk("trig_onehot", multi, 0);
    chk("steal_count", steal_n, e_steal);
    chk("overrun_count", ovr_n, (ovr_at >= 0) ? 1 : 0);
    chk("voice_active", o_voice_active, m_act);
    chk("voice_key", o_voice_key, model_keys());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: timeout reached, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [NK-1:0] k;
    @(negedge i_clk);
    do_reset();

    do_scan(32'h8, -1, '0);
    chk("single_key", o_voice_key[KW-1:0], 5'd3);
    chk("single_act", o_voice_active, 4'b0001);

    do_reset();
    do_scan(32'h3E, -1, '0);
    chk("steal_keys", o_voice_key, {5'd4, 5'd3, 5'd2, 5'd5});
    chk("steal_pulses", e_steal, 1);

    do_reset();
    do_scan(32'h1E, -1, '0);
    do_scan(32'h21C, -1, '0);
    chk("relprs_key0", o_voice_key[KW-1:0], 5'd9);
    chk("relprs_act", o_voice_active, 4'b1111);

    do_scan(32'h0F0, 10, 32'h3000);
    do_scan(32'h3000, -1, '0);
    chk("overrun_pick", o_voice_active, 4'b0011);

    i_keys = 32'h0000_1240; i_tick = 1'b1;
    @(negedge i_clk);
    i_tick = 1'b0;
    repeat (NK + 8) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    chk("midrst_busy", o_busy, 1'b0);
    chk("midrst_act", o_voice_active, '0);
    chk("midrst_keys", o_voice_key, '0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    model_reset();
    @(negedge i_clk);
    do_scan(32'h0000_1240, -1, '0);
    chk("midrst_realloc", o_voice_key[KW-1:0], 5'd6);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: k = $urandom & $urandom;
        1: k = $urandom & $urandom & $urandom;
        2: k = m_snap ^ (32'h1 << $urandom_range(0, NK-1));
        default: k = '0;
      endcase
      do_scan(k, -1, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice scheduler that sits between `keyboard_decoder` and the synthesizer datapath. It shares a small pool of NUM_VOICES oscillator voices among the 32 key-state bits of the key bitmap. On each sample tick it snapshots the bitmap, frees voices whose keys were released, assigns newly pressed keys to free voices, and steals the oldest voice when the pool is full. Its outputs drive the per-voice key index and gate/trigger inputs of the modulator synth.

## Interface
Parameters:
- NUM_KEYS, 32: width of key bitmap; KEY_W = $clog2(NUM_KEYS)
- NUM_VOICES, 4: voice pool size, legal range 1..8
- AGE_W, 4: per-voice age counter width, saturating

Ports (reset i_rst_n, asynchronous, active-low; clock i_clk):
- i_clk  input  1  system clock (AUD_BCLK domain)
- i_rst_n  input  1  asynchronous active-low reset
- i_keys  input  NUM_KEYS  key bitmap, 1 = held; synchronous to i_clk
- i_tick  input  1  one-cycle pulse requesting a scan (one per audio frame)
- o_voice_active  output  NUM_VOICES  bit v = voice v gated on
- o_voice_key  output  NUM_VOICES*KEY_W  voice v key index at [KEY_W*v +: KEY_W]
- o_voice_trig  output  NUM_VOICES  one-cycle pulse: voice v (re)assigned, restart phase/envelope
- o_steal  output  1  one-cycle pulse: an active voice was stolen
- o_busy  output  1  scan in progress
- o_overrun  output  1  one-cycle pulse: i_tick arrived while busy

## Operation
- Registers: prev[NUM_KEYS], snap[NUM_KEYS], idx[KEY_W], per-voice active, key, age[AGE_W].
- FSM states: S_IDLE, S_REL, S_PRS.
- S_IDLE: on i_tick, snap <= i_keys, prev <= snap (old snapshot kept for edge detection as prev), idx <= 0, go S_REL. Edge detection in the scan uses prev (before this tick) against snap (this tick).
- S_REL: for key idx, if prev[idx]=1 and snap[idx]=0, clear active on every voice with active=1 and key=idx. A key with no voice, because it was stolen earlier, causes no action. idx++; after idx = NUM_KEYS-1, set idx <= 0 and go S_PRS.
- S_PRS: for key idx, if prev[idx]=0 and snap[idx]=1, allocate as follows:
  - If any voice is free, take the lowest-index free voice.
  - Otherwise steal the active voice with the largest age, ties to lowest index, and pulse o_steal.
  - On the chosen voice: active <= 1, key <= idx, age <= 0, trig pulse.
  - All other active voices: age <= age+1, saturating at 2^AGE_W-1.
  - idx++; after the last key, go S_IDLE.
- Releases are fully processed before presses, so a release and a press in the same tick never cause a steal while a freed voice exists.
- Free voices keep their last key value. Only active is cleared on release.
- i_tick outside S_IDLE is ignored: snap/prev unchanged, o_overrun pulses.
- Reset: state S_IDLE, idx 0, prev/snap 0, all voice active/key/age 0. All outputs 0.

## Timing
- i_tick sampled high in S_IDLE at edge T: o_busy = 1 from T+1 through T+2*NUM_KEYS (64 cycles at default), then 0.
- Key k is evaluated in S_REL during cycle T+1+k and in S_PRS during cycle T+1+NUM_KEYS+k. The resulting voice-register update is visible one cycle later.
- o_voice_trig / o_steal are registered and high exactly one cycle, coincident with the updated o_voice_key/o_voice_active.
- A new i_tick is accepted on the first cycle o_busy = 0, with no dead cycle.
- Reset asserted mid-scan clears everything immediately (asynchronous). After deassertion, the next scan treats all currently held keys as new presses.
- Only one voice changes per S_PRS cycle. At most one trig bit is high per cycle.

## Test plan
- Reset: hold i_rst_n=0 with i_keys=32'hFFFF_FFFF and toggling i_tick -> all outputs 0. After release with no tick, outputs stay 0.
- Single press: i_keys=32'h8, pulse i_tick -> o_busy high 64 cycles. Voice0 active, key 3, o_voice_trig=4'b0001 for one cycle. o_steal never asserts.
- Overflow steal: from reset, i_keys=32'h3E (keys 1..5), one tick -> keys 1..4 go to voices 0..3 (ages end 3,2,1,0 before key 5). Key 5 steals voice0, giving o_voice_key = {4,3,2,5} (v3..v0), o_steal one pulse, five trig pulses total.
- Release+press same scan: voices hold keys 1..4. Set i_keys=32'h21C (keys 2,3,4,9) and tick -> voice0 freed in S_REL, key 9 takes voice0 in S_PRS, no o_steal.
- Overrun: pulse i_tick at cycle 10 of a scan with a changed i_keys -> o_overrun one pulse, scan result unchanged. The following idle tick picks up the new bitmap.
- Mid-scan reset: assert i_rst_n=0 during S_PRS -> o_busy and all voices 0 in the same cycle. After deassertion, a tick with keys held reallocates them from voice0.
